scalar_mult_ctrl: RTL and testbench

Left-to-right double-and-add sequencer computing R = k·P over the curve in `elliptic_curve_structs::params`. It sits directly downstream of `point_double` and its companion point-add unit. It owns one instance-port interface to each unit, drives their operands and resets, and captures their results into an accumulator Q. It is the top of the scalar-multiplication datapath that key generation and ECDH call.

---
 rtl/scalar_mult_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl
// Left-to-right double-and-add sequencer computing R = k*P with external
// point-double and point-add units. The controller latches k and P, scans
// for the leading set bit, then walks the remaining bits. It runs one
// double per bit and one add per set bit, and accumulates the result in Q.
//
// Ports:
//   clk, Reset           clock (rising edge), async active-high reset
//   start, k, Px, Py     request, scalar and base point (latched in IDLE)
//   busy, done           operation in progress / one-cycle completion pulse
//   inf, err             result is point at infinity / aborted on Qx == Px
//   Rx, Ry               result, held until the next accepted start
//   dbl_*                doubler reset, operands (= Q), done, result
//   add_*                adder reset, operands (= Q, P), done, result
module scalar_mult_ctrl (
    input  logic         clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [255:0] k,
    input  logic [255:0] Px,
    input  logic [255:0] Py,
    output logic         busy,
    output logic         done,
    output logic         inf,
    output logic         err,
    output logic [255:0] Rx,
    output logic [255:0] Ry,
    output logic         dbl_reset,
    output logic [255:0] dbl_Px,
    output logic [255:0] dbl_Py,
    input  logic         dbl_done,
    input  logic [255:0] dbl_Rx,
    input  logic [255:0] dbl_Ry,
    output logic         add_reset,
    output logic [255:0] add_Px,
    output logic [255:0] add_Py,
    output logic [255:0] add_Qx,
    output logic [255:0] add_Qy,
    input  logic         add_done,
    input  logic [255:0] add_Rx,
    input  logic [255:0] add_Ry
);

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        LOAD,
        DBL_RST,
        DBL_RUN,
        ADD_RST,
        ADD_RUN,
        NEXT,
        FIN
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     idx_q, idx_d;
    logic [255:0]   qx_q, qx_d, qy_q, qy_d;
    logic [255:0]   kr_q, kr_d, pxr_q, pxr_d, pyr_q, pyr_d;
    logic           first_q, first_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           inf_q, inf_d;
    logic           err_q, err_d;
    logic [255:0]   rx_q, rx_d, ry_q, ry_d;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            kr_q    <= '0;
            pxr_q   <= '0;
            pyr_q   <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inf_q   <= 1'b0;
            err_q   <= 1'b0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            kr_q    <= kr_d;
            pxr_q   <= pxr_d;
            pyr_q   <= pyr_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            inf_q   <= inf_d;
            err_q   <= err_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        kr_d    = kr_q;
        pxr_d   = pxr_q;
        pyr_d   = pyr_q;
        first_d = first_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        inf_d   = inf_q;
        err_d   = err_q;
        rx_d    = rx_q;
        ry_d    = ry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    kr_d    = k;
                    pxr_d   = Px;
                    pyr_d   = Py;
                    inf_d   = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = 8'd255;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (kr_q[idx_q]) begin
                    state_d = LOAD;
                end else if (idx_q == 8'd0) begin
                    inf_d   = 1'b1;
                    qx_d    = '0;
                    qy_d    = '0;
                    state_d = FIN;
                end else begin
                    idx_d = idx_q - 8'd1;
                end
            end
            LOAD: begin
                qx_d = pxr_q;
                qy_d = pyr_q;
                if (idx_q == 8'd0) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - 8'd1;
                    state_d = DBL_RST;
                end
            end
            DBL_RST: begin
                first_d = 1'b1;
                state_d = DBL_RUN;
            end
            DBL_RUN: begin
                first_d = 1'b0;
                // A done left over from the previous run may still be visible
                // on the first released cycle, so it is not trusted there.
                if (!first_q && dbl_done) begin
                    qx_d    = dbl_Rx;
                    qy_d    = dbl_Ry;
                    state_d = kr_q[idx_q] ? ADD_RST : NEXT;
                end
            end
            ADD_RST: begin
                // Q == +/-P shares the x coordinate; the adder cannot handle it.
                if (qx_q == pxr_q) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    first_d = 1'b1;
                    state_d = ADD_RUN;
                end
            end
            ADD_RUN: begin
                first_d = 1'b0;
                if (!first_q && add_done) begin
                    qx_d    = add_Rx;
                    qy_d    = add_Ry;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == 8'd0) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - 8'd1;
                    state_d = DBL_RST;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                rx_d    = err_q ? '0 : qx_q;
                ry_d    = err_q ? '0 : qy_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign inf       = inf_q;
    assign err       = err_q;
    assign Rx        = rx_q;
    assign Ry        = ry_q;

    assign dbl_reset = (state_q != DBL_RUN);
    assign dbl_Px    = qx_q;
    assign dbl_Py    = qy_q;

    assign add_reset = (state_q != ADD_RUN);
    assign add_Px    = qx_q;
    assign add_Py    = qy_q;
    assign add_Qx    = pxr_q;
    assign add_Qy    = pyr_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
module tb_scalar_mult_ctrl;

    logic         clk;
    logic         Reset;
    logic         start;
    logic [255:0] k, Px, Py;
    logic         busy, done, inf, err;
    logic [255:0] Rx, Ry;
    logic         dbl_reset, dbl_done;
    logic [255:0] dbl_Px, dbl_Py, dbl_Rx, dbl_Ry;
    logic         add_reset, add_done;
    logic [255:0] add_Px, add_Py, add_Qx, add_Qy, add_Rx, add_Ry;

    int total;
    int bad;

    scalar_mult_ctrl dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .k         (k),
        .Px        (Px),
        .Py        (Py),
        .busy      (busy),
        .done      (done),
        .inf       (inf),
        .err       (err),
        .Rx        (Rx),
        .Ry        (Ry),
        .dbl_reset (dbl_reset),
        .dbl_Px    (dbl_Px),
        .dbl_Py    (dbl_Py),
        .dbl_done  (dbl_done),
        .dbl_Rx    (dbl_Rx),
        .dbl_Ry    (dbl_Ry),
        .add_reset (add_reset),
        .add_Px    (add_Px),
        .add_Py    (add_Py),
        .add_Qx    (add_Qx),
        .add_Qy    (add_Qy),
        .add_done  (add_done),
        .add_Rx    (add_Rx),
        .add_Ry    (add_Ry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock units: done four cycles after release, result = operand + 100.
    // dbl_mode 1 makes the doubler return x unchanged.
    int           dbl_mode;
    int           dcnt, acnt;
    logic [255:0] seen_dpx, seen_dpy, seen_apx, seen_apy, seen_aqx, seen_aqy;

    always @(posedge clk) begin
        if (dbl_reset) begin
            dcnt     <= 0;
            dbl_done <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            if (dcnt == 0) begin
                seen_dpx <= dbl_Px;
                seen_dpy <= dbl_Py;
            end
            if (dcnt == 3) begin
                dbl_done <= 1'b1;
                dbl_Rx   <= (dbl_mode == 1) ? dbl_Px : dbl_Px + 256'd100;
                dbl_Ry   <= dbl_Py + 256'd100;
            end
        end
    end

    always @(posedge clk) begin
        if (add_reset) begin
            acnt     <= 0;
            add_done <= 1'b0;
        end else begin
            acnt <= acnt + 1;
            if (acnt == 0) begin
                seen_apx <= add_Px;
                seen_apy <= add_Py;
                seen_aqx <= add_Qx;
                seen_aqy <= add_Qy;
            end
            if (acnt == 3) begin
                add_done <= 1'b1;
                add_Rx   <= add_Px + 256'd100;
                add_Ry   <= add_Py + 256'd100;
            end
        end
    end

    // Release counters: cycles in which each unit was out of reset.
    int dbl_rel, add_rel;
    always @(negedge clk) begin
        if (!dbl_reset) dbl_rel <= dbl_rel + 1;
        if (!add_reset) add_rel <= add_rel + 1;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int busy_low;
    int ncyc;

    // Issues one request and waits (bounded) for done. Optionally asserts a
    // second start with a different scalar while the first is in flight.
    task automatic run_op(input logic [255:0] kv, input logic [255:0] px, input logic [255:0] py,
                          input bit inject, output int n);
        @(negedge clk);
        dbl_rel  = 0;
        add_rel  = 0;
        busy_low = 0;
        k     = kv;
        Px    = px;
        Py    = py;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = -1;
        for (int c = 1; c <= 1500; c++) begin
            if (inject && c == 10) begin
                k     = 256'd2;
                Px    = 256'd9;
                Py    = 256'd11;
                start = 1'b1;
            end
            if (inject && c == 12) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                n = c;
                break;
            end
            if (!busy) busy_low++;
        end
        chk("busy_clear_at_done", {255'd0, busy}, 256'd0);
        @(posedge clk);
        #1 chk("done_one_cycle", {255'd0, done}, 256'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        dbl_mode = 0;
        dbl_rel  = 0;
        add_rel  = 0;
        dcnt     = 0;
        acnt     = 0;
        dbl_done = 1'b0;
        add_done = 1'b0;
        dbl_Rx   = '0;
        dbl_Ry   = '0;
        add_Rx   = '0;
        add_Ry   = '0;
        start    = 1'b0;
        k        = '0;
        Px       = '0;
        Py       = '0;
        Reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_inf", {255'd0, inf}, 256'd0);
        chk("rst_err", {255'd0, err}, 256'd0);
        chk("rst_rx", Rx, 256'd0);
        chk("rst_ry", Ry, 256'd0);
        chk("rst_dbl_reset", {255'd0, dbl_reset}, 256'd1);
        chk("rst_add_reset", {255'd0, add_reset}, 256'd1);
        @(negedge clk);
        Reset = 1'b0;

        // k = 0: full scan, infinity
        run_op(256'd0, 256'd5, 256'd7, 1'b0, ncyc);
        chk("k0_latency", ncyc, 257);
        chk("k0_inf", {255'd0, inf}, 256'd1);
        chk("k0_rx", Rx, 256'd0);
        chk("k0_ry", Ry, 256'd0);
        chk("k0_dbl_rel", dbl_rel, 0);
        chk("k0_busy", busy_low, 0);

        // k = 1: result is P, no unit released
        run_op(256'd1, 256'd5, 256'd7, 1'b0, ncyc);
        chk("k1_latency", ncyc, 258);
        chk("k1_rx", Rx, 256'd5);
        chk("k1_ry", Ry, 256'd7);
        chk("k1_inf", {255'd0, inf}, 256'd0);
        chk("k1_dbl_rel", dbl_rel, 0);
        chk("k1_add_rel", add_rel, 0);

        // k = 3: one double, one add
        run_op(256'd3, 256'd5, 256'd7, 1'b0, ncyc);
        chk("k3_latency", ncyc, 270);
        chk("k3_dbl_px", seen_dpx, 256'd5);
        chk("k3_dbl_py", seen_dpy, 256'd7);
        chk("k3_add_px", seen_apx, 256'd105);
        chk("k3_add_py", seen_apy, 256'd107);
        chk("k3_add_qx", seen_aqx, 256'd5);
        chk("k3_add_qy", seen_aqy, 256'd7);
        chk("k3_rx", Rx, 256'd205);
        chk("k3_ry", Ry, 256'd207);
        chk("k3_busy", busy_low, 0);
        chk("k3_err", {255'd0, err}, 256'd0);

        // k = 2 with doubler returning x unchanged: no add, no coincidence
        dbl_mode = 1;
        run_op(256'd2, 256'd5, 256'd7, 1'b0, ncyc);
        chk("k2c_latency", ncyc, 264);
        chk("k2c_err", {255'd0, err}, 256'd0);
        chk("k2c_rx", Rx, 256'd5);
        chk("k2c_ry", Ry, 256'd107);
        chk("k2c_add_rel", add_rel, 0);

        // Reset pulsed mid-doubling
        @(negedge clk);
        k     = 256'hFF;
        Px    = 256'd5;
        Py    = 256'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ncyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (!dbl_reset) begin
                ncyc = c;
                break;
            end
        end
        chk("rm_reached_dbl_run", {255'd0, (ncyc > 0)}, 256'd1);
        #2 Reset = 1'b1;
        #1;
        chk("rm_busy", {255'd0, busy}, 256'd0);
        chk("rm_done", {255'd0, done}, 256'd0);
        chk("rm_rx", Rx, 256'd0);
        chk("rm_ry", Ry, 256'd0);
        chk("rm_dbl_reset", {255'd0, dbl_reset}, 256'd1);
        chk("rm_add_reset", {255'd0, add_reset}, 256'd1);
        chk("rm_dbl_px", dbl_Px, 256'd0);
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rm_no_done", {255'd0, done}, 256'd0);
        dbl_mode = 0;
        run_op(256'd1, 256'd5, 256'd7, 1'b0, ncyc);
        chk("rm_k1_latency", ncyc, 258);
        chk("rm_k1_rx", Rx, 256'd5);
        chk("rm_k1_ry", Ry, 256'd7);

        // k = 3 with doubler returning x unchanged: Qx == Px aborts
        dbl_mode = 1;
        run_op(256'd3, 256'd5, 256'd7, 1'b0, ncyc);
        chk("k3c_latency", ncyc, 264);
        chk("k3c_err", {255'd0, err}, 256'd1);
        chk("k3c_rx", Rx, 256'd0);
        chk("k3c_ry", Ry, 256'd0);
        chk("k3c_add_rel", add_rel, 0);
        chk("k3c_inf", {255'd0, inf}, 256'd0);

        // start while busy is ignored
        dbl_mode = 0;
        run_op(256'd1, 256'd6, 256'd8, 1'b1, ncyc);
        chk("ign_latency", ncyc, 258);
        chk("ign_rx", Rx, 256'd6);
        chk("ign_ry", Ry, 256'd8);
        chk("ign_err", {255'd0, err}, 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
